// File: rtl/sequential_store_if.sv
// Handshake bundle between the ShuffleUnit / store address generator and the
// sequential store packer, including the AXI W channel it drives.
interface sequential_store_if #(
    parameter int unsigned NrLanes      = 4,
    parameter int unsigned DLEN         = 64,
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 64
);
    localparam int unsigned NbE      = DLEN / 4 * NrLanes;
    localparam int unsigned BusNb    = AxiDataWidth / 4;
    localparam int unsigned BusNSize = $clog2(BusNb);
    localparam int unsigned PtrW     = $clog2(NbE);

    logic                      rx_shfu_valid_i;
    logic                      rx_shfu_ready_o;
    logic [NbE*4-1:0]          rx_shfu_nb_i;
    logic [NbE-1:0]            rx_shfu_en_i;
    logic                      meta_ctrl_valid_i;
    logic                      meta_ctrl_ready_o;
    logic [PtrW-1:0]           meta_seq_nb_ptr_i;
    logic                      txn_ctrl_valid_i;
    logic                      txn_ctrl_ready_o;
    logic [AxiAddrWidth-1:0]   txn_addr_i;
    logic                      txn_is_head_i;
    logic [7:0]                txn_rmn_beat_i;
    logic [BusNSize:0]         txn_lbn_i;
    logic                      txn_is_final_i;
    logic                      axi_w_valid_o;
    logic                      axi_w_ready_i;
    logic [AxiDataWidth-1:0]   axi_w_data_o;
    logic [AxiDataWidth/8-1:0] axi_w_strb_o;
    logic                      axi_w_last_o;

    modport slave (
        input  rx_shfu_valid_i, rx_shfu_nb_i, rx_shfu_en_i,
        input  meta_ctrl_valid_i, meta_seq_nb_ptr_i,
        input  txn_ctrl_valid_i, txn_addr_i, txn_is_head_i, txn_rmn_beat_i,
        input  txn_lbn_i, txn_is_final_i, axi_w_ready_i,
        output rx_shfu_ready_o, meta_ctrl_ready_o, txn_ctrl_ready_o,
        output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o
    );

    modport master (
        output rx_shfu_valid_i, rx_shfu_nb_i, rx_shfu_en_i,
        output meta_ctrl_valid_i, meta_seq_nb_ptr_i,
        output txn_ctrl_valid_i, txn_addr_i, txn_is_head_i, txn_rmn_beat_i,
        output txn_lbn_i, txn_is_final_i, axi_w_ready_i,
        input  rx_shfu_ready_o, meta_ctrl_ready_o, txn_ctrl_ready_o,
        input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o
    );
endinterface

// File: rtl/sequential_store.sv
// Packs sequential-order nibble entries from the ShuffleUnit into AXI W beats,
// one beat window per store-address-generator control beat.
module sequential_store #(
    parameter int unsigned NrLanes      = 4,
    parameter int unsigned DLEN         = 64,
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sequential_store_if.slave bus
);
    localparam int unsigned NbE      = DLEN / 4 * NrLanes;
    localparam int unsigned BusNb    = AxiDataWidth / 4;
    localparam int unsigned BusNSize = $clog2(BusNb);
    localparam int unsigned PtrW     = $clog2(NbE);
    localparam int unsigned CW       = ((PtrW > BusNSize) ? PtrW : BusNSize) + 2;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SERIAL = 1'b1;

    logic [0:0]          state_q;
    logic [PtrW-1:0]     ptr_q;
    logic [BusNSize:0]   cnt_q;

    logic [NbE-1:0][3:0] fifo_nb_q [2];
    logic [NbE-1:0]      fifo_en_q [2];
    logic                wptr_q, rptr_q;
    logic [1:0]          fcnt_q;
    logic                fifo_full, fifo_empty, enq, deq;
    logic [NbE-1:0][3:0] head_nb;
    logic [NbE-1:0]      head_en;

    logic                meta_occ_q, meta_avail, meta_enq, start;
    logic [PtrW-1:0]     meta_ptr_q, meta_ptr;

    logic [CW-1:0]       lo, hi, base, need, avail, ncopy;
    logic                step, partial, cstep, w_hs;
    logic                valid_q, last_q;
    logic [BusNb-1:0][3:0] bdata_q, bdata_n, cp_nb;
    logic [BusNb-1:0]    bmask_q, bmask_n, cp_en, hit;

    logic unused_addr;
    assign unused_addr = ^bus.txn_addr_i[AxiAddrWidth-1:BusNSize];

    // Input FIFO
    assign fifo_full           = (fcnt_q == 2'd2);
    assign fifo_empty          = (fcnt_q == 2'd0);
    assign bus.rx_shfu_ready_o = !fifo_full;
    assign enq                 = bus.rx_shfu_valid_i && !fifo_full;
    assign head_nb             = fifo_nb_q[rptr_q];
    assign head_en             = fifo_en_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_nb_q[wptr_q] <= bus.rx_shfu_nb_i;
            fifo_en_q[wptr_q] <= bus.rx_shfu_en_i;
        end
    end

    // Flow-through meta: an arriving request can start in the same cycle.
    assign meta_avail            = meta_occ_q || bus.meta_ctrl_valid_i;
    assign meta_ptr              = meta_occ_q ? meta_ptr_q : bus.meta_seq_nb_ptr_i;
    assign start                 = (state_q == IDLE) && bus.txn_ctrl_valid_i && meta_avail;
    assign bus.meta_ctrl_ready_o = !meta_occ_q || start;
    assign meta_enq              = bus.meta_ctrl_valid_i && bus.meta_ctrl_ready_o;

    // Beat window and how much of it the head entry can still fill
    assign lo      = bus.txn_is_head_i ? CW'(bus.txn_addr_i[BusNSize-1:0]) : '0;
    assign hi      = (bus.txn_rmn_beat_i == 8'd0) ? CW'(bus.txn_lbn_i) : CW'(BusNb);
    assign base    = lo + CW'(cnt_q);
    assign need    = hi - base;
    assign avail   = CW'(NbE) - CW'(ptr_q);
    assign partial = need > avail;
    assign ncopy   = partial ? avail : need;
    assign w_hs    = valid_q && bus.axi_w_ready_i;
    assign step    = (state_q == SERIAL) && bus.txn_ctrl_valid_i && !fifo_empty &&
                     (!valid_q || bus.axi_w_ready_i);
    assign cstep   = step && !partial;
    assign deq     = step && (partial || (need == avail) || bus.txn_is_final_i);

    assign bus.txn_ctrl_ready_o = cstep;

    for (genvar j = 0; j < BusNb; j++) begin : g_nib
        logic [CW-1:0]   off;
        logic [PtrW-1:0] src;
        assign off      = CW'(j) - base;
        assign src      = ptr_q + off[PtrW-1:0];
        assign hit[j]   = step && (CW'(j) >= base) && (off < ncopy);
        assign cp_en[j] = head_en[src];
        assign cp_nb[j] = head_en[src] ? head_nb[src] : 4'h0;
    end

    // An accepted beat is dropped before the same-cycle step writes into it.
    always_comb begin
        bdata_n = w_hs ? '0 : bdata_q;
        bmask_n = w_hs ? '0 : bmask_q;
        for (int j = 0; j < BusNb; j++) begin
            if (hit[j]) begin
                bdata_n[j] = cp_nb[j];
                bmask_n[j] = cp_en[j];
            end
        end
    end

    for (genvar b = 0; b < BusNb / 2; b++) begin : g_strb
        assign bus.axi_w_strb_o[b] = bmask_q[2*b] | bmask_q[2*b+1];
    end

    assign bus.axi_w_valid_o = valid_q;
    assign bus.axi_w_last_o  = last_q;
    assign bus.axi_w_data_o  = bdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            bdata_q    <= '0;
            bmask_q    <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            fcnt_q     <= '0;
            meta_occ_q <= 1'b0;
            meta_ptr_q <= '0;
        end else begin
            wptr_q     <= wptr_q ^ enq;
            rptr_q     <= rptr_q ^ deq;
            fcnt_q     <= fcnt_q + 2'(enq) - 2'(deq);
            meta_occ_q <= (meta_occ_q && !start) || (meta_enq && !(start && !meta_occ_q));
            if (meta_enq && (meta_occ_q || !start)) meta_ptr_q <= bus.meta_seq_nb_ptr_i;

            if (start) begin
                state_q <= SERIAL;
                ptr_q   <= meta_ptr;
                cnt_q   <= '0;
            end else if (step) begin
                ptr_q <= deq ? '0 : ptr_q + need[PtrW-1:0];
                cnt_q <= partial ? cnt_q + avail[BusNSize:0] : '0;
                if (cstep && bus.txn_is_final_i) state_q <= IDLE;
            end

            bdata_q <= bdata_n;
            bmask_q <= bmask_n;
            if (cstep) begin
                valid_q <= 1'b1;
                last_q  <= (bus.txn_rmn_beat_i == 8'd0);
            end else if (w_hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    a_beat_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == SERIAL && bus.txn_ctrl_valid_i) |-> (hi > base));
endmodule

// File: tb/tb_sequential_store.sv
// Randomized bench: a nibble-stream model predicts every W beat; directed
// cases pin the model and cover stall, throughput and mid-beat reset.
module tb_sequential_store;
    localparam int TO = 5000;

    typedef struct { logic [255:0] nb; logic [63:0] en; } ent_t;
    typedef struct { logic [63:0] addr; logic head; logic [7:0] rmn; logic [5:0] lbn; logic fin; } txn_t;
    typedef struct { logic [127:0] data; logic [15:0] strb; logic last; } beat_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    sequential_store_if #(.NrLanes(4), .DLEN(64), .AxiDataWidth(128), .AxiAddrWidth(64)) bus ();
    sequential_store #(.NrLanes(4), .DLEN(64), .AxiDataWidth(128), .AxiAddrWidth(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    max_run = 0;
    int    run = 0;
    int    rdy_mode = 1;
    bit    gap_en = 0;
    bit    abort = 0;
    ent_t  rx_q[$];
    logic [5:0] meta_q[$];
    txn_t  txn_q[$];
    beat_t exp_q[$];
    ent_t  last_ents[$];

    task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Model: the request is a flat nibble stream starting at entry0[ptr];
    // each beat consumes hi-lo nibbles placed at bus nibbles lo..hi-1.
    task automatic gen_req(input int ptr, input int nbeats, input int off, input int lbn, input bit full_en);
        int total, nent, pos, lo, hi;
        logic [3:0] snb[$];
        logic sen[$];
        ent_t e;
        txn_t t;
        beat_t b;
        total = (nbeats == 1) ? lbn - off : (32 - off) + (nbeats - 2) * 32 + lbn;
        nent  = (ptr + total + 63) / 64;
        last_ents.delete();
        for (int i = 0; i < nent; i++) begin
            for (int w = 0; w < 8; w++) e.nb[32*w +: 32] = $urandom;
            e.en = full_en ? '1 : ({$urandom, $urandom} | {$urandom, $urandom});
            rx_q.push_back(e);
            last_ents.push_back(e);
            for (int k = 0; k < 64; k++) begin
                snb.push_back(e.nb[4*k +: 4]);
                sen.push_back(e.en[k]);
            end
        end
        meta_q.push_back(6'(ptr));
        pos = ptr;
        for (int k = 0; k < nbeats; k++) begin
            lo = (k == 0) ? off : 0;
            hi = (k == nbeats - 1) ? lbn : 32;
            t.addr = {$urandom, $urandom};
            t.addr[4:0] = off[4:0];
            t.head = (k == 0);
            t.rmn  = 8'(nbeats - 1 - k);
            t.lbn  = (k == nbeats - 1) ? 6'(lbn) : 6'($urandom_range(32));
            t.fin  = (k == nbeats - 1);
            txn_q.push_back(t);
            b.data = '0;
            b.strb = '0;
            b.last = (k == nbeats - 1);
            for (int j = lo; j < hi; j++) begin
                if (sen[pos]) begin
                    b.data[4*j +: 4] = snb[pos];
                    b.strb[j/2] = 1'b1;
                end
                pos++;
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < TO; n++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && rx_q.size() == 0 && meta_q.size() == 0 && txn_q.size() == 0) break;
        end
        if (n == TO) timeout("drain");
        repeat (3) @(negedge clk_i);
    endtask

    // Drivers: each starts an item just after a rising edge and holds it until accepted
    initial begin
        ent_t e;
        bus.rx_shfu_valid_i = 0; bus.rx_shfu_nb_i = '0; bus.rx_shfu_en_i = '0;
        forever begin
            @(posedge clk_i); #1;
            bus.rx_shfu_valid_i = 0;
            if (!abort && rx_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
                e = rx_q.pop_front();
                bus.rx_shfu_valid_i = 1; bus.rx_shfu_nb_i = e.nb; bus.rx_shfu_en_i = e.en;
                for (int t = 0; ; t++) begin
                    @(negedge clk_i);
                    if (bus.rx_shfu_ready_o || abort) break;
                    if (t == TO) begin timeout("rx_handshake"); break; end
                end
            end
        end
    end

    initial begin
        bus.meta_ctrl_valid_i = 0; bus.meta_seq_nb_ptr_i = '0;
        forever begin
            @(posedge clk_i); #1;
            bus.meta_ctrl_valid_i = 0;
            if (!abort && meta_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
                bus.meta_seq_nb_ptr_i = meta_q.pop_front();
                bus.meta_ctrl_valid_i = 1;
                for (int t = 0; ; t++) begin
                    @(negedge clk_i);
                    if (bus.meta_ctrl_ready_o || abort) break;
                    if (t == TO) begin timeout("meta_handshake"); break; end
                end
            end
        end
    end

    initial begin
        txn_t x;
        bus.txn_ctrl_valid_i = 0; bus.txn_addr_i = '0; bus.txn_is_head_i = 0;
        bus.txn_rmn_beat_i = '0; bus.txn_lbn_i = '0; bus.txn_is_final_i = 0;
        forever begin
            @(posedge clk_i); #1;
            bus.txn_ctrl_valid_i = 0;
            if (!abort && txn_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
                x = txn_q.pop_front();
                bus.txn_ctrl_valid_i = 1; bus.txn_addr_i = x.addr; bus.txn_is_head_i = x.head;
                bus.txn_rmn_beat_i = x.rmn; bus.txn_lbn_i = x.lbn; bus.txn_is_final_i = x.fin;
                for (int t = 0; ; t++) begin
                    @(negedge clk_i);
                    if (bus.txn_ctrl_ready_o || abort) break;
                    if (t == TO) begin timeout("txn_handshake"); break; end
                end
            end
        end
    end

    initial begin
        bus.axi_w_ready_i = 0;
        forever begin
            @(posedge clk_i); #1;
            case (rdy_mode)
                0:       bus.axi_w_ready_i = ($urandom_range(3) != 0);
                1:       bus.axi_w_ready_i = 1;
                default: bus.axi_w_ready_i = 0;
            endcase
        end
    end

    // Compare process: every accepted beat against the model, stall stability
    initial begin
        beat_t b;
        logic [127:0] pdata;
        logic [15:0] pstrb;
        logic plast;
        bit pstall;
        pstall = 0; pdata = '0; pstrb = '0; plast = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                pstall = 0;
                run = 0;
            end else begin
                run = bus.axi_w_valid_o ? run + 1 : 0;
                if (run > max_run) max_run = run;
                if (pstall)
                    chk("w_stable", bus.axi_w_valid_o && bus.axi_w_data_o == pdata &&
                        bus.axi_w_strb_o == pstrb && bus.axi_w_last_o == plast,
                        {bus.axi_w_valid_o, bus.axi_w_last_o, bus.axi_w_strb_o, bus.axi_w_data_o[109:0]},
                        {1'b1, plast, pstrb, pdata[109:0]});
                if (bus.axi_w_valid_o && !bus.axi_w_ready_i)
                    chk("txn_ready_in_stall", !bus.txn_ctrl_ready_o, 128'(bus.txn_ctrl_ready_o), 128'd0);
                if (bus.axi_w_valid_o && bus.axi_w_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 0, bus.axi_w_data_o, 128'd0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("w_data", bus.axi_w_data_o == b.data, bus.axi_w_data_o, b.data);
                        chk("w_strb_last", {bus.axi_w_strb_o, bus.axi_w_last_o} == {b.strb, b.last},
                            128'({bus.axi_w_strb_o, bus.axi_w_last_o}), 128'({b.strb, b.last}));
                    end
                end
                pstall = bus.axi_w_valid_o && !bus.axi_w_ready_i;
                pdata = bus.axi_w_data_o; pstrb = bus.axi_w_strb_o; plast = bus.axi_w_last_o;
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        chk(name, bus.rx_shfu_ready_o && bus.meta_ctrl_ready_o && !bus.txn_ctrl_ready_o &&
            !bus.axi_w_valid_o && bus.axi_w_strb_o == 16'h0 && !bus.axi_w_last_o,
            128'({bus.rx_shfu_ready_o, bus.meta_ctrl_ready_o, bus.txn_ctrl_ready_o,
                  bus.axi_w_valid_o, bus.axi_w_strb_o, bus.axi_w_last_o}),
            128'({3'b110, 1'b0, 16'h0, 1'b0}));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset_ctrl");
        chk("reset_data", bus.axi_w_data_o == '0, bus.axi_w_data_o, 128'd0);
        rst_ni = 1;
        @(negedge clk_i);

        // 1: aligned 2-beat burst from one fully enabled entry
        gen_req(0, 2, 0, 32, 1);
        chk("model_t1_b0", exp_q[0].data == last_ents[0].nb[127:0] && exp_q[0].strb == 16'hFFFF && !exp_q[0].last,
            exp_q[0].data, last_ents[0].nb[127:0]);
        chk("model_t1_b1", exp_q[1].data == last_ents[0].nb[255:128] && exp_q[1].strb == 16'hFFFF && exp_q[1].last,
            exp_q[1].data, last_ents[0].nb[255:128]);
        drain();

        // 2: unaligned single beat, nibbles 6..19
        gen_req(0, 1, 6, 20, 1);
        chk("model_t2_strb", exp_q[0].strb == 16'h03F8, 128'(exp_q[0].strb), 128'h03F8);
        chk("model_t2_data", exp_q[0].data == {48'h0, last_ents[0].nb[55:0], 24'h0},
            exp_q[0].data, {48'h0, last_ents[0].nb[55:0], 24'h0});
        drain();

        // 3: beat straddles two entries
        gen_req(56, 1, 0, 32, 1);
        chk("model_t3", exp_q[0].data == {last_ents[1].nb[95:0], last_ents[0].nb[255:224]} &&
            exp_q[0].strb == 16'hFFFF && exp_q[0].last,
            exp_q[0].data, {last_ents[1].nb[95:0], last_ents[0].nb[255:224]});
        drain();

        // 4: W backpressure with the FIFO filling up behind the stalled beat
        rdy_mode = 2;
        gen_req(0, 4, 0, 32, 1);
        for (n = 0; n < TO; n++) begin
            @(negedge clk_i);
            if (bus.axi_w_valid_o) break;
        end
        if (n == TO) timeout("t4_valid");
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_ready", !bus.rx_shfu_ready_o && !bus.txn_ctrl_ready_o,
                128'({bus.rx_shfu_ready_o, bus.txn_ctrl_ready_o}), 128'd0);
            @(negedge clk_i);
        end
        rdy_mode = 1;
        drain();

        // 5: 4-beat burst, one beat per cycle
        max_run = 0;
        gen_req(0, 4, 0, 32, 1);
        drain();
        chk("t5_throughput", max_run == 4, 128'(max_run), 128'd4);

        // Randomized traffic
        rdy_mode = 0;
        gap_en = 1;
        for (int r = 0; r < 40; r++) begin
            int nb, off, lbn;
            nb  = $urandom_range(1, 4);
            off = $urandom_range(0, 31);
            lbn = (nb == 1) ? $urandom_range(off + 1, 32) : $urandom_range(1, 32);
            gen_req($urandom_range(0, 63), nb, off, lbn, $urandom_range(1) == 1);
        end
        for (n = 0; n < 20000; n++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && rx_q.size() == 0 && txn_q.size() == 0) break;
        end
        if (n == 20000) timeout("random_drain");
        gap_en = 0;
        rdy_mode = 1;
        repeat (4) @(negedge clk_i);

        // 6: reset while a beat is stalled and the FIFO is full
        rdy_mode = 2;
        gen_req(0, 4, 0, 32, 1);
        for (n = 0; n < TO; n++) begin
            @(negedge clk_i);
            if (bus.axi_w_valid_o && !bus.rx_shfu_ready_o) break;
        end
        if (n == TO) timeout("t6_full");
        rst_ni = 0;
        abort = 1;
        @(negedge clk_i);
        check_idle_outputs("t6_reset");
        repeat (2) @(negedge clk_i);
        rx_q.delete(); meta_q.delete(); txn_q.delete(); exp_q.delete();
        abort = 0;
        rdy_mode = 1;
        rst_ni = 1;
        @(negedge clk_i);
        check_idle_outputs("t6_after_reset");

        // Recovery after reset with sparse enables
        gen_req(5, 1, 3, 30, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
